// File: rtl/n64_vmux_pkg.sv
// Shared definitions for the N64 video bus: colour width, pixel layout,
// bus phase encodings and the VDATA slice/format helpers.
package n64_vmux_pkg;

  localparam int color_width = 7;
  localparam int SYNC_W      = 4;
  localparam int PIX_W       = SYNC_W + 3 * color_width;

  // Bus phase encodings, in the order they appear on D[6:0].
  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_R    = 2'd1,
    PH_G    = 2'd2,
    PH_B    = 2'd3
  } phase_e;

  typedef logic [color_width-1:0] color_t;

  // One pixel as carried through the FIFO: sync nibble on top, then R, G, B.
  typedef struct packed {
    logic [SYNC_W-1:0] sync;
    color_t            r;
    color_t            g;
    color_t            b;
  } pixel_t;

  // Sync nibble as it sits on the bus during the sync phase.
  function automatic color_t vdata_sync(input logic [SYNC_W-1:0] sync);
    return color_t'(sync);
  endfunction

  // Colour as it sits on the bus: full precision, or the 5 MSBs with the
  // two LSBs cleared when the source is in 15-bit mode.
  function automatic color_t vdata_color(input color_t c, input logic full);
    return full ? c : {c[color_width-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/n64_vmux_if.sv
// Upstream pixel handshake plus N64 digital video bus, bundled so the mux
// and its stimulus source share one connection.
interface n64_vmux_if
  import n64_vmux_pkg::*;
#(
  parameter int UCNT_W = 8
);

  logic                     pix_valid_i;
  logic                     pix_ready_o;
  logic [SYNC_W-1:0]        pix_sync_i;
  logic [3*color_width-1:0] pix_rgb_i;
  logic                     n15bit_mode_i;
  logic                     uclr_i;
  logic                     nDSYNC_o;
  logic [color_width-1:0]   D_o;
  logic [1:0]               phase_o;
  logic                     underrun_o;
  logic [UCNT_W-1:0]        ucnt_o;

  // Pixel source / bus observer side.
  modport master (
    output pix_valid_i, pix_sync_i, pix_rgb_i, n15bit_mode_i, uclr_i,
    input  pix_ready_o, nDSYNC_o, D_o, phase_o, underrun_o, ucnt_o
  );

  // Mux side.
  modport slave (
    input  pix_valid_i, pix_sync_i, pix_rgb_i, n15bit_mode_i, uclr_i,
    output pix_ready_o, nDSYNC_o, D_o, phase_o, underrun_o, ucnt_o
  );

endinterface

// File: rtl/n64_vmux_fifo.sv
// Small synchronous FIFO holding pixels until the bus reaches its next
// sync phase. Pointers wrap naturally; occupancy is tracked separately.
module n64_vmux_fifo #(
  parameter  int WIDTH = 25,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  // Storage write.
  // NOTE: the array has no reset; flushing is done by the pointers/count,
  // which keeps the storage a plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/n64_vmux.sv
// N64 digital video bus serializer: buffers upstream pixels and plays them
// out as a free-running sync/R/G/B phase cycle, inserting idle pixels when
// the buffer runs dry.
module n64_vmux
  import n64_vmux_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int UCNT_W     = 8
) (
  input  logic        VCLK,
  input  logic        nRST,
  n64_vmux_if.slave   bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  phase_e                 phase_q;
  phase_e                 phase_d;
  logic                   enter_sync;
  logic                   push;
  logic                   pop;
  logic                   underrun_evt;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [PIX_W-1:0]       fifo_rdata;
  pixel_t                 head;
  pixel_t                 shadow_q;
  pixel_t                 shadow_d;
  logic                   ndsync_q;
  logic                   ndsync_d;
  color_t                 d_q;
  color_t                 d_d;
  logic                   underrun_q;
  logic [UCNT_W-1:0]      ucnt_q;

  // The edge that enters the sync phase is the one that consumes a pixel.
  assign enter_sync   = (phase_q == PH_B);
  assign pop          = enter_sync & ~fifo_empty;
  assign underrun_evt = enter_sync & fifo_empty;

  // Ready depends only on occupancy, never on a same-edge pop.
  assign bus.pix_ready_o = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push            = bus.pix_valid_i & bus.pix_ready_o;

  assign head = pixel_t'(fifo_rdata);

  n64_vmux_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (VCLK),
    .rst_n (nRST),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.pix_sync_i, bus.pix_rgb_i}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Phase register: starts on B so the first edge after reset enters sync.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) phase_q <= PH_B;
    else       phase_q <= phase_d;
  end

  // Next phase: free-running modulo-4 count.
  always_comb begin
    phase_d = phase_e'(phase_q + 2'd1);
  end

  // Next shadow pixel and next bus word for the phase being entered.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    shadow_d = shadow_q;
    ndsync_d = 1'b1;
    d_d      = '0;
    if (enter_sync) begin
      if (!fifo_empty) begin
        shadow_d = head;
      end else begin
        // Idle pixel: keep the last sync so the raster stays coherent.
        shadow_d.r = '0;
        shadow_d.g = '0;
        shadow_d.b = '0;
      end
    end
    unique case (phase_d)
      PH_SYNC: begin
        ndsync_d = 1'b0;
        d_d      = vdata_sync(shadow_d.sync);
      end
      PH_R:    d_d = vdata_color(shadow_q.r, bus.n15bit_mode_i);
      PH_G:    d_d = vdata_color(shadow_q.g, bus.n15bit_mode_i);
      PH_B:    d_d = vdata_color(shadow_q.b, bus.n15bit_mode_i);
    endcase
  end

  // Shadow pixel and registered bus outputs.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      shadow_q   <= '{sync: 4'hF, r: '0, g: '0, b: '0};
      ndsync_q   <= 1'b1;
      d_q        <= '0;
      underrun_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      ndsync_q   <= ndsync_d;
      d_q        <= d_d;
      underrun_q <= underrun_evt;
    end
  end

  // Saturating idle-pixel counter; a clear wins over a same-edge increment.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      ucnt_q <= '0;
    end else if (bus.uclr_i) begin
      ucnt_q <= '0;
    end else if (underrun_evt && (ucnt_q != '1)) begin
      ucnt_q <= ucnt_q + 1'b1;
    end
  end

  assign bus.nDSYNC_o   = ndsync_q;
  assign bus.D_o        = d_q;
  assign bus.phase_o    = phase_q;
  assign bus.underrun_o = underrun_q;
  assign bus.ucnt_o     = ucnt_q;

endmodule

// File: tb/tb_n64_vmux.sv
// Scoreboard bench for n64_vmux: a driver applies stimulus on the falling
// edge and queues the bus word a pixel-level reference model predicts;
// a monitor pops and compares after each rising edge.
module tb_n64_vmux;

  localparam int DEPTH  = 4;
  localparam int UCNT_W = 8;

  typedef struct {
    logic [1:0] ph;
    logic       nd;
    logic [6:0] d;
    logic       und;
    logic [7:0] ucnt;
    logic       rdy;
  } exp_t;

  logic VCLK;
  logic nRST;

  n64_vmux_if #(.UCNT_W(UCNT_W)) bus ();

  n64_vmux #(
    .FIFO_DEPTH (DEPTH),
    .UCNT_W     (UCNT_W)
  ) dut (
    .VCLK (VCLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: pixels waiting, pixel on the bus, edge index.
  logic [24:0] mq[$];
  exp_t        sbq[$];
  logic [3:0]  m_sync;
  logic [20:0] m_rgb;
  int          m_edge;
  int          m_ucnt;
  int          last_ph;
  bit          m_accepted;

  initial begin
    VCLK = 1'b0;
    forever #5 VCLK = ~VCLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sync = 4'hF;
    m_rgb  = '0;
    m_edge = 0;
    m_ucnt = 0;
  endtask

  // One VCLK edge of the reference: which phase is entered, what the bus
  // shows, and how the waiting pixel list changes.
  task automatic model_edge(input logic v, input logic [3:0] s, input logic [20:0] rgb,
                            input logic mode, input logic clr);
    exp_t        e;
    int          ph;
    bit          rdy_before;
    logic [24:0] cur;
    logic [6:0]  comp;
    ph = m_edge % 4;
    m_edge++;
    rdy_before = (mq.size() != DEPTH);
    e.und = 1'b0;
    if (ph == 0) begin
      if (mq.size() > 0) begin
        cur    = mq.pop_front();
        m_sync = cur[24:21];
        m_rgb  = cur[20:0];
      end else begin
        m_rgb = '0;
        e.und = 1'b1;
      end
    end
    m_accepted = v && rdy_before;
    if (m_accepted) mq.push_back({s, rgb});
    if (clr) m_ucnt = 0;
    else if (e.und && m_ucnt < 255) m_ucnt++;
    case (ph)
      1:       comp = m_rgb[20:14];
      2:       comp = m_rgb[13:7];
      default: comp = m_rgb[6:0];
    endcase
    if (!mode) comp = comp - (comp % 7'd4);
    e.ph   = 2'(ph);
    e.nd   = (ph != 0);
    e.d    = (ph == 0) ? {3'b000, m_sync} : comp;
    e.ucnt = 8'(m_ucnt);
    e.rdy  = (mq.size() != DEPTH);
    last_ph = ph;
    sbq.push_back(e);
  endtask

  task automatic step(input logic v, input logic [3:0] s, input logic [20:0] rgb,
                      input logic mode, input logic clr);
    @(negedge VCLK);
    nRST              = 1'b1;
    bus.pix_valid_i   = v;
    bus.pix_sync_i    = s;
    bus.pix_rgb_i     = rgb;
    bus.n15bit_mode_i = mode;
    bus.uclr_i        = clr;
    model_edge(v, s, rgb, mode, clr);
  endtask

  task automatic idle(input int n, input logic mode);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 21'h0, mode, 1'b0);
  endtask

  task automatic check_reset_state();
    check("rst_phase",    32'(bus.phase_o),     32'd3);
    check("rst_ndsync",   32'(bus.nDSYNC_o),    32'd1);
    check("rst_d",        32'(bus.D_o),         32'd0);
    check("rst_ready",    32'(bus.pix_ready_o), 32'd1);
    check("rst_underrun", 32'(bus.underrun_o),  32'd0);
    check("rst_ucnt",     32'(bus.ucnt_o),      32'd0);
  endtask

  // Monitor: the bus presents a word after every active edge.
  always @(posedge VCLK) begin
    exp_t e;
    if (nRST) begin
      #1;
      if (sbq.size() == 0) begin
        check("sb_expectation_present", 32'd0, 32'd1);
      end else begin
        e = sbq.pop_front();
        check("phase",    32'(bus.phase_o),     32'(e.ph));
        check("ndsync",   32'(bus.nDSYNC_o),    32'(e.nd));
        check("d",        32'(bus.D_o),         32'(e.d));
        check("underrun", 32'(bus.underrun_o),  32'(e.und));
        check("ucnt",     32'(bus.ucnt_o),      32'(e.ucnt));
        check("ready",    32'(bus.pix_ready_o), 32'(e.rdy));
      end
    end
  end

  initial begin
    int  n;
    bit  found;
    nRST              = 1'b0;
    bus.pix_valid_i   = 1'b0;
    bus.pix_sync_i    = '0;
    bus.pix_rgb_i     = '0;
    bus.n15bit_mode_i = 1'b1;
    bus.uclr_i        = 1'b0;
    model_reset();
    repeat (3) @(negedge VCLK);
    check_reset_state();

    // Idle bus long enough to saturate the underrun counter, then clear it.
    idle(1030, 1'b1);
    step(1'b0, 4'h0, 21'h0, 1'b1, 1'b1);
    idle(6, 1'b1);

    // Directed pixel, full colour then 15-bit formatting.
    step(1'b1, 4'h6, {7'h7F, 7'h55, 7'h01}, 1'b1, 1'b0);
    idle(10, 1'b1);
    step(1'b1, 4'h6, {7'h7F, 7'h55, 7'h01}, 1'b0, 1'b0);
    idle(10, 1'b0);

    // Streaming: valid held high, data advances on each acceptance.
    n = 0;
    for (int i = 0; i < 48; i++) begin
      step(1'b1, 4'(n), {7'(n), 7'(n + 1), 7'(n + 2)}, 1'b1, 1'b0);
      if (m_accepted) n++;
    end
    idle(20, 1'b1);

    // Push on a sync-phase edge into an empty FIFO.
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 0 && (m_edge % 4) == 0) break;
      step(1'b0, 4'h0, 21'h0, 1'b1, 1'b0);
    end
    step(1'b1, 4'h9, {7'h12, 7'h34, 7'h56}, 1'b1, 1'b0);
    idle(10, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 21'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end
    idle(12, 1'b1);

    // Queue three pixels, then reset during the G phase.
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(mq.size() < 3, 4'(i), {7'(i), 7'h2A, 7'h15}, 1'b1, 1'b0);
      if (last_ph == 2 && mq.size() == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("reset_setup_reached", 32'(found), 32'd1);
    @(posedge VCLK);
    #3;
    nRST = 1'b0;
    #1;
    check_reset_state();
    model_reset();
    idle(12, 1'b1);

    @(posedge VCLK);
    #2;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
